// File: rtl/alu_multicycle.sv
// Multi-cycle ALU with valid/ready handshake; iterative MUL/DIV. Optional SRA via ALU_SRA_EN.
// Latency: 1 cycle for single-cycle ops, illegal opcodes and DIV-by-zero; WIDTH+1 for MUL/DIV.
// Backpressure: the result holds in DONE until out_ready; in_ready is low while busy or stalled.
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rda,
  input  logic [WIDTH-1:0] rdx,
  input  logic [3:0]       alu_decode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic [WIDTH-1:0] remain,
  output logic             illegal,
  output logic             div_zero
);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0101;
  localparam logic [3:0] OP_DIV = 4'b0110;
  localparam logic [3:0] OP_OR  = 4'b0111;
  localparam logic [3:0] OP_AND = 4'b1000;
  localparam logic [3:0] OP_XOR = 4'b1001;
  localparam logic [3:0] OP_SLL = 4'b1010;
  localparam logic [3:0] OP_SRL = 4'b1011;
  localparam logic [3:0] OP_SLT = 4'b1100;
`ifdef ALU_SRA_EN
  localparam logic [3:0] OP_SRA = 4'b1101;
`endif
  localparam logic [SHW-1:0] CNT_LAST = {SHW{1'b1}};

  state_t           state, next_state;
  logic [SHW-1:0]   cnt;
  logic             is_div_q;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] work_hi, work_lo;

  logic             accept;
  logic [WIDTH-1:0] sc_result;
  logic             sc_illegal, sc_dz, is_iter;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic             div_ok;
  logic [WIDTH-1:0] step_hi, step_lo;

  // DONE with out_ready behaves as IDLE so a new request can overlap the result hand-off.
  assign out_valid = (state == DONE);
  assign in_ready  = ((state == IDLE) || (state == DONE)) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;

  always_comb begin
    sc_result  = '0;
    sc_illegal = 1'b0;
    sc_dz      = 1'b0;
    is_iter    = 1'b0;
    case (alu_decode)
      OP_ADD: sc_result = rda + rdx;
      OP_SUB: sc_result = rda - rdx;
      OP_MUL: is_iter = 1'b1;
      OP_DIV: begin
        if (rdx == '0) begin
          sc_dz     = 1'b1;
          sc_result = '1;
        end else begin
          is_iter = 1'b1;
        end
      end
      OP_OR:  sc_result = rda | rdx;
      OP_AND: sc_result = rda & rdx;
      OP_XOR: sc_result = rda ^ rdx;
      OP_SLL: sc_result = rda << rdx[SHW-1:0];
      OP_SRL: sc_result = rda >> rdx[SHW-1:0];
      OP_SLT: sc_result = {{(WIDTH-1){1'b0}}, ($signed(rda) < $signed(rdx))};
`ifdef ALU_SRA_EN
      OP_SRA: sc_result = $signed(rda) >>> rdx[SHW-1:0];
`endif
      default: sc_illegal = 1'b1;
    endcase
  end

  // One iteration step: shift-add multiply or restoring divide on {work_hi, work_lo}.
  always_comb begin
    mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    div_shift = {work_hi, work_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    div_ok    = !div_diff[WIDTH];
    step_hi   = work_hi;
    step_lo   = work_lo;
    if (is_div_q) begin
      step_hi = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      step_lo = {work_lo[WIDTH-2:0], div_ok};
    end else begin
      {step_hi, step_lo} = {mul_sum, work_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: begin
        if (accept)                        next_state = is_iter ? ITER : DONE;
        else if (state == DONE && out_ready) next_state = IDLE;
      end
      ITER:    if (cnt == CNT_LAST) next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      is_div_q <= 1'b0;
      opnd     <= '0;
      work_hi  <= '0;
      work_lo  <= '0;
      result   <= '0;
      Hi       <= '0;
      Lo       <= '0;
      remain   <= '0;
      illegal  <= 1'b0;
      div_zero <= 1'b0;
    end else if (accept) begin
      cnt      <= '0;
      is_div_q <= (alu_decode == OP_DIV);
      opnd     <= (alu_decode == OP_DIV) ? rdx : rda;
      work_hi  <= '0;
      work_lo  <= (alu_decode == OP_DIV) ? rda : rdx;
      illegal  <= sc_illegal;
      div_zero <= sc_dz;
      if (!is_iter) result <= sc_result;
      if (sc_dz)    remain <= rda;
    end else if (state == ITER) begin
      cnt     <= cnt + SHW'(1);
      work_hi <= step_hi;
      work_lo <= step_lo;
      if (cnt == CNT_LAST) begin
        result <= step_lo;
        if (is_div_q) begin
          remain <= step_hi;
        end else begin
          Hi <= step_hi;
          Lo <= step_lo;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: driver pushes model results, monitor checks each presented result.
module tb_alu_multicycle;

  localparam int W   = 32;
  localparam int SHW = $clog2(W);

  localparam logic [3:0] OP_ADD = 4'b0001, OP_SUB = 4'b0010, OP_MUL = 4'b0101, OP_DIV = 4'b0110;
  localparam logic [3:0] OP_OR  = 4'b0111, OP_AND = 4'b1000, OP_XOR = 4'b1001, OP_SLL = 4'b1010;
  localparam logic [3:0] OP_SRL = 4'b1011, OP_SLT = 4'b1100, OP_SRA = 4'b1101;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] rda = '0;
  logic [W-1:0] rdx = '0;
  logic [3:0]   alu_decode = '0;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result, Hi, Lo, remain;
  logic         illegal, div_zero;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rda(rda), .rdx(rdx), .alu_decode(alu_decode),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .Hi(Hi), .Lo(Lo), .remain(remain),
    .illegal(illegal), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res, hi, lo, rem;
    logic         ill, dz;
    int           lat;
    int           acc;
  } exp_t;

  exp_t         q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           rdy_mode = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0, m_rem = '0;
  bit           seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // out_ready: 0 = held high, 1 = random, 2 = held low
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        1:       out_ready = ($urandom_range(0, 3) != 0);
        2:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Reference model: expected outcome of an op from plain arithmetic, tracking Hi/Lo/remain.
  task automatic push_expected(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int acc);
    exp_t e;
    logic [2*W-1:0] p;
    logic [SHW-1:0] sh;
    sh = b[SHW-1:0];
    e.res = '0; e.ill = 1'b0; e.dz = 1'b0; e.lat = 1; e.acc = acc;
    case (op)
      OP_ADD: e.res = a + b;
      OP_SUB: e.res = a - b;
      OP_OR:  e.res = a | b;
      OP_AND: e.res = a & b;
      OP_XOR: e.res = a ^ b;
      OP_SLL: e.res = a << sh;
      OP_SRL: e.res = a >> sh;
      OP_SLT: e.res = ($signed(a) < $signed(b)) ? 1 : 0;
      OP_MUL: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        m_hi = p[2*W-1:W]; m_lo = p[W-1:0];
        e.res = m_lo; e.lat = W + 1;
      end
      OP_DIV: begin
        if (b == 0) begin
          e.res = '1; m_rem = a; e.dz = 1'b1;
        end else begin
          e.res = a / b; m_rem = a % b; e.lat = W + 1;
        end
      end
`ifdef ALU_SRA_EN
      OP_SRA: e.res = $signed(a) >>> sh;
`endif
      default: e.ill = 1'b1;
    endcase
    e.hi = m_hi; e.lo = m_lo; e.rem = m_rem;
    q.push_back(e);
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output int waited);
    bit done;
    @(posedge clk);
    #1;
    in_valid = 1'b1; rda = a; rdx = b; alu_decode = op;
    waited = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1'b1;
        push_expected(op, a, b, cyc);
      end else begin
        waited++;
        if (waited > 300) begin
          checks++; errors++;
          $display("FAIL accept_timeout: op %b not accepted after %0d cycles", op, waited);
          done = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; rda = $urandom; rdx = $urandom; alu_decode = 4'($urandom_range(0, 15));
  endtask

  task automatic expect_busy(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("busy_in_ready", {{(W-1){1'b0}}, in_ready}, '0);
      check("busy_out_valid", {{(W-1){1'b0}}, out_valid}, '0);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, want 0", q.size());
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_out_valid"}, {{(W-1){1'b0}}, out_valid}, '0);
    check({tag, "_result"}, result, '0);
    check({tag, "_hi"}, Hi, '0);
    check({tag, "_lo"}, Lo, '0);
    check({tag, "_remain"}, remain, '0);
    check({tag, "_flags"}, {{(W-2){1'b0}}, illegal, div_zero}, '0);
    check({tag, "_in_ready"}, {{(W-1){1'b0}}, in_ready}, 1);
  endtask

  // Monitor: compare every presented result against the scoreboard head, pop on hand-off.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: got res=%h with empty scoreboard", result);
        end else begin
          if (!seen) begin
            seen = 1'b1;
            checks++;
            if (cyc - q[0].acc != q[0].lat) begin
              errors++;
              $display("FAIL latency: got %0d want %0d", cyc - q[0].acc, q[0].lat);
            end
          end
          checks++;
          if (result !== q[0].res || Hi !== q[0].hi || Lo !== q[0].lo || remain !== q[0].rem ||
              illegal !== q[0].ill || div_zero !== q[0].dz) begin
            errors++;
            $display("FAIL result: got res=%h hi=%h lo=%h rem=%h ill=%b dz=%b want res=%h hi=%h lo=%h rem=%h ill=%b dz=%b",
                     result, Hi, Lo, remain, illegal, div_zero,
                     q[0].res, q[0].hi, q[0].lo, q[0].rem, q[0].ill, q[0].dz);
          end
          if (!out_ready) begin
            checks++;
            if (in_ready !== 1'b0) begin
              errors++;
              $display("FAIL stall_in_ready: got %b want 0", in_ready);
            end
          end else begin
            void'(q.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [3:0]   op;
    logic [W-1:0] a, b;

    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    check_zero_outputs("reset");

    issue(OP_ADD, 32'd5, 32'd3, w);
    issue(OP_SUB, 32'd5, 32'd3, w);
    issue(OP_OR,  32'h55, 32'hAA, w);
    issue(OP_AND, 32'h55, 32'hAA, w);
    issue(OP_XOR, 32'h55, 32'hAA, w);
    issue(OP_MUL, 32'hFFFF_FFFF, 32'd2, w);
    expect_busy(W);
    issue(OP_DIV, 32'd10, 32'd3, w);
    issue(OP_DIV, 32'd7, 32'd0, w);
    issue(OP_SLL, 32'h8000_0000, 32'h10, w);
    issue(OP_SRL, 32'h00F0_F0F0, 32'd5, w);
    issue(OP_SRL, 32'h00F0_F0F0, 32'h25, w);
    issue(OP_SLL, 32'h1234_5678, 32'd0, w);
    issue(OP_SLT, 32'hFFFF_FFFF, 32'd1, w);
    issue(OP_SLT, 32'd1, 32'hFFFF_FFFF, w);
    issue(4'b1110, 32'd9, 32'd9, w);
    issue(OP_SRA, 32'h8000_0000, 32'd4, w);
    issue(4'b0000, 32'd1, 32'd1, w);
    drain();

    // Hold the MUL result for five cycles, then hand it off while a new ADD is accepted.
    rdy_mode = 2;
    issue(OP_MUL, 32'd123457, 32'd98765, w);
    expect_busy(W);
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid", {{(W-1){1'b0}}, out_valid}, 1);
    end
    rdy_mode = 0;
    issue(OP_ADD, 32'd9, 32'd4, w);
    check("bp_same_edge_accept", w, 0);
    drain();

    rdy_mode = 1;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
      issue(op, a, b, w);
    end
    rdy_mode = 0;
    drain();

    // Abort a DIV mid-iteration with an asynchronous reset.
    issue(OP_DIV, 32'd1000, 32'd7, w);
    repeat (9) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_zero_outputs("mid_reset");
    q.delete();
    m_hi = '0; m_lo = '0; m_rem = '0;
    @(posedge clk);
    #3 rst = 1'b0;
    issue(OP_ADD, 32'd1, 32'd1, w);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
